branch_resolve_unit: RTL and testbench
======================================

// Module: branch_resolve_unit
// PURPOSE
// - Pipelined successor to the single-cycle branch controller. Resolves branches/jumps in EX, predicts direction at
//   fetch with a parametrised BHT of 2-bit saturating counters, issues a registered PC redirect on mispredict.
// - Sits between EX (ALU result, flags, immediate) and the fetch PC mux; optionally keeps performance counters.
// PARAMETERS
// - XLEN        32      data/address width; PCs are word addresses of XLEN-2 bits
// - BHT_ENTRIES 64      BHT depth, power of two >= 2; index IDXW = log2(BHT_ENTRIES) = pc[IDXW-1:0]
// - CTR_INIT    2'b01   reset value of every BHT counter (weakly not-taken)
// PORTS
// - clk            in   1         clock, all state on rising edge
// - rst_n          in   1         asynchronous active-low reset
// - f_pc           in   XLEN-2    fetch word-PC for lookup
// - f_pred_taken   out  1         BHT[f_pc idx][1], combinational
// - r_valid        in   1         EX holds a branch-class instruction this cycle
// - r_mode         in   2         00 DISABLE, 01 JMP, 10 CMP, 11 ALU (register-indirect)
// - r_pc           in   XLEN-2    word-PC of resolving instruction
// - r_imm          in   XLEN      byte offset, sign-extended
// - r_alu          in   XLEN      ALU result (target for ALU mode; bit 0 = compare result)
// - r_alu_z        in   1         ALU zero flag
// - r_cmp_z        in   1         1: condition = r_alu_z; 0: condition = r_alu[0]
// - r_cmp_inv      in   1         invert condition
// - r_pred_taken   in   1         prediction carried down the pipe with the instruction
// - redirect       out  1         registered; fetch must load redirect_pc next cycle
// - redirect_pc    out  XLEN-2    registered corrected word-PC
// - squash         out  1         registered; equals redirect; flush IF/ID
// BEHAVIOUR
// - Reset (async assert, sync release): redirect=0, redirect_pc=0, squash=0, holdoff=0, all BHT counters=CTR_INIT.
// - Target: JMP/CMP -> r_pc + (r_imm >>> 2) (arithmetic shift, mod 2^(XLEN-2)); ALU -> r_alu[XLEN-1:2]. Fall-through = r_pc+1 (wraps).
// - Taken: JMP/ALU -> 1; CMP -> (r_cmp_z ? r_alu_z : r_alu[0]) ^ r_cmp_inv; DISABLE -> 0, no action.
// - Mispredict: CMP/JMP -> taken != r_pred_taken; ALU -> always (no target prediction).
// - Latency 1: on accepted mispredict, next cycle redirect=squash=1 for exactly one cycle,
//   redirect_pc = taken ? target : fall-through.
// - Holdoff: in the cycle redirect=1, r_valid is ignored (wrong-path): no redirect, no BHT update, no stats.
// - BHT update on accepted CMP only: taken -> counter+1 saturating at 3; not-taken -> counter-1 saturating at 0.
//   JMP/ALU/DISABLE never touch BHT.
// - Same-cycle lookup and update of one index: f_pred_taken returns pre-update value (no bypass).
// - Back-to-back accepted branches without mispredict each update BHT, no bubbles.
// - Reset mid-redirect: redirect/squash drop immediately, pending redirect lost.
// CONFIGURATION
// - BRANCH_STATS_EN defined: adds out ports stat_branches[31:0], stat_mispredicts[31:0]; +1 per accepted non-DISABLE
//   resolve / per mispredict; wrap at 2^32; reset to 0; ignored r_valid not counted.
// - Undefined: ports and counters absent; all other behaviour identical.
// TESTING
// - Reset, f_pc=any -> f_pred_taken=0 (CTR_INIT 01), redirect=0.
// - CMP r_pc=0x10, r_imm=-8, cmp_z=1, alu_z=1, inv=0, pred=0 -> next cycle redirect=1, redirect_pc=0x0E; BHT[0x10]=2.
// - Same CMP three more times, pred=1 -> no redirect; counter saturates at 3; one not-taken -> 2, f_pred_taken still 1.
// - ALU mode r_alu=0x0000_1004, pred=1 -> redirect_pc=0x401; r_valid CMP mispredict in redirect cycle -> ignored.
// - CMP not taken pred=1, r_pc=0x3FFF_FFFF -> redirect_pc=0 (wrap); rst_n low during redirect -> redirect=0 at once.
// - BRANCH_STATS_EN: 5 branches, 2 mispredicts, 1 ignored -> stat_branches=5, stat_mispredicts=2.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: EX-stage branch resolution, BHT direction prediction, registered redirect.
// Optional performance counters are enabled by defining BRANCH_STATS_EN.
module branch_resolve_unit #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned BHT_ENTRIES = 64,
    parameter logic [1:0]  CTR_INIT    = 2'b01
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [XLEN-3:0]   f_pc,
    output logic              f_pred_taken,
    input  logic              r_valid,
    input  logic [1:0]        r_mode,
    input  logic [XLEN-3:0]   r_pc,
    input  logic [XLEN-1:0]   r_imm,
    input  logic [XLEN-1:0]   r_alu,
    input  logic              r_alu_z,
    input  logic              r_cmp_z,
    input  logic              r_cmp_inv,
    input  logic              r_pred_taken,
    output logic              redirect,
    output logic [XLEN-3:0]   redirect_pc,
    output logic              squash
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]       stat_branches,
    output logic [31:0]       stat_mispredicts
`endif
);

    localparam int unsigned PCW  = XLEN - 2;
    localparam int unsigned IDXW = $clog2(BHT_ENTRIES);

    localparam logic [1:0] MODE_DIS = 2'b00;
    localparam logic [1:0] MODE_JMP = 2'b01;
    localparam logic [1:0] MODE_CMP = 2'b10;
    localparam logic [1:0] MODE_ALU = 2'b11;

    logic [1:0]     r_bht [BHT_ENTRIES];

    logic [IDXW-1:0] w_f_idx;
    logic [IDXW-1:0] w_r_idx;
    logic [PCW-1:0]  w_target;
    logic [PCW-1:0]  w_fall;
    logic [PCW-1:0]  w_next_pc;
    logic            w_taken;
    logic            w_mispredict;
    logic            w_accept;
    logic            w_bht_we;
    logic [1:0]      w_ctr_old;
    logic [1:0]      w_ctr_new;
    logic            w_unused;

    assign w_unused = ^{r_alu[1], r_imm[1:0]};

    // Lookup reads the registered counter: a same-cycle update is not bypassed.
    assign w_f_idx      = f_pc[IDXW-1:0];
    assign f_pred_taken = r_bht[w_f_idx][1];

    // The cycle carrying a redirect is wrong-path, so EX input is ignored.
    assign w_accept = r_valid && !redirect && (r_mode != MODE_DIS);
    assign w_fall   = r_pc + PCW'(1);

    always_comb begin
        w_target     = r_pc + r_imm[XLEN-1:2];
        w_taken      = 1'b0;
        w_mispredict = 1'b0;
        case (r_mode)
            MODE_JMP: begin
                w_taken      = 1'b1;
                w_mispredict = !r_pred_taken;
            end
            MODE_CMP: begin
                w_taken      = (r_cmp_z ? r_alu_z : r_alu[0]) ^ r_cmp_inv;
                w_mispredict = w_taken != r_pred_taken;
            end
            MODE_ALU: begin
                w_target     = r_alu[XLEN-1:2];
                w_taken      = 1'b1;
                w_mispredict = 1'b1;
            end
            default: begin
                w_taken      = 1'b0;
                w_mispredict = 1'b0;
            end
        endcase
    end

    assign w_next_pc = w_taken ? w_target : w_fall;

    // Saturating 2-bit counter step for the resolving index.
    assign w_r_idx   = r_pc[IDXW-1:0];
    assign w_bht_we  = w_accept && (r_mode == MODE_CMP);
    assign w_ctr_old = r_bht[w_r_idx];

    always_comb begin
        w_ctr_new = w_ctr_old;
        if (w_taken) begin
            if (w_ctr_old != 2'b11) w_ctr_new = w_ctr_old + 2'b01;
        end else begin
            if (w_ctr_old != 2'b00) w_ctr_new = w_ctr_old - 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(BHT_ENTRIES); i++) r_bht[i] <= CTR_INIT;
        end else if (w_bht_we) begin
            r_bht[w_r_idx] <= w_ctr_new;
        end
    end

    // One-cycle redirect pulse; it self-clears because the redirect cycle blocks acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect    <= 1'b0;
            squash      <= 1'b0;
            redirect_pc <= '0;
        end else begin
            redirect    <= w_accept && w_mispredict;
            squash      <= w_accept && w_mispredict;
            if (w_accept && w_mispredict) redirect_pc <= w_next_pc;
        end
    end

`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else if (w_accept) begin
            stat_branches <= stat_branches + 32'd1;
            if (w_mispredict) stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Testbench for branch_resolve_unit: vector table plus scoreboard queue of expected redirects.
module tb_branch_resolve_unit;

    localparam int unsigned XLEN = 32;
    localparam int unsigned PCW  = XLEN - 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [PCW-1:0]  f_pc = '0;
    logic            f_pred_taken;
    logic            r_valid = 1'b0;
    logic [1:0]      r_mode = 2'b00;
    logic [PCW-1:0]  r_pc = '0;
    logic [XLEN-1:0] r_imm = '0;
    logic [XLEN-1:0] r_alu = '0;
    logic            r_alu_z = 1'b0;
    logic            r_cmp_z = 1'b0;
    logic            r_cmp_inv = 1'b0;
    logic            r_pred_taken = 1'b0;
    logic            redirect;
    logic [PCW-1:0]  redirect_pc;
    logic            squash;
`ifdef BRANCH_STATS_EN
    logic [31:0]     stat_branches;
    logic [31:0]     stat_mispredicts;
`endif

    branch_resolve_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .f_pc         (f_pc),
        .f_pred_taken (f_pred_taken),
        .r_valid      (r_valid),
        .r_mode       (r_mode),
        .r_pc         (r_pc),
        .r_imm        (r_imm),
        .r_alu        (r_alu),
        .r_alu_z      (r_alu_z),
        .r_cmp_z      (r_cmp_z),
        .r_cmp_inv    (r_cmp_inv),
        .r_pred_taken (r_pred_taken),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .squash       (squash)
`ifdef BRANCH_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            valid;
        logic [1:0]      mode;
        logic [PCW-1:0]  pc;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] alu;
        logic            alu_z;
        logic            cmp_z;
        logic            inv;
        logic            pred;
        logic [PCW-1:0]  fpc;
        logic            exp_fpred;
        logic            exp_redir;
        logic [PCW-1:0]  exp_pc;
    } vec_t;

    typedef struct {
        logic           redir;
        logic [PCW-1:0] pc;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    localparam logic [1:0] DIS = 2'b00, JMP = 2'b01, CMP = 2'b10, ALU = 2'b11;

    function automatic vec_t mk(logic valid, logic [1:0] mode, logic [PCW-1:0] pc,
                                logic [XLEN-1:0] imm, logic [XLEN-1:0] alu, logic alu_z,
                                logic cmp_z, logic inv, logic pred, logic [PCW-1:0] fpc,
                                logic exp_fpred, logic exp_redir, logic [PCW-1:0] exp_pc);
        vec_t v;
        v.valid = valid; v.mode = mode; v.pc = pc; v.imm = imm; v.alu = alu;
        v.alu_z = alu_z; v.cmp_z = cmp_z; v.inv = inv; v.pred = pred; v.fpc = fpc;
        v.exp_fpred = exp_fpred; v.exp_redir = exp_redir; v.exp_pc = exp_pc;
        return v;
    endfunction

    function automatic vec_t idle(logic [PCW-1:0] fpc, logic exp_fpred);
        return mk(1'b0, DIS, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, fpc, exp_fpred, 1'b0, '0);
    endfunction

    task automatic chk(string name, logic [PCW-1:0] act, logic [PCW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, check the lookup, then compare the registered outcome.
    task automatic step(vec_t v);
        exp_t e;
        exp_t got;
        r_valid = v.valid; r_mode = v.mode; r_pc = v.pc; r_imm = v.imm; r_alu = v.alu;
        r_alu_z = v.alu_z; r_cmp_z = v.cmp_z; r_cmp_inv = v.inv; r_pred_taken = v.pred;
        f_pc = v.fpc;
        #1;
        chk("f_pred_taken", PCW'(f_pred_taken), PCW'(v.exp_fpred));
        e.redir = v.exp_redir;
        e.pc    = v.exp_pc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk("redirect", PCW'(redirect), PCW'(got.redir));
        chk("squash", PCW'(squash), PCW'(got.redir));
        if (got.redir) chk("redirect_pc", redirect_pc, got.pc);
    endtask

    initial begin
        // Main vector table.
        vecs.push_back(idle(30'h10, 1'b0));
        vecs.push_back(mk(1, CMP, 30'h10, -32'sd8, 0, 1, 1, 0, 0, 30'h10, 0, 1, 30'h0E));
        vecs.push_back(mk(1, CMP, 30'h10, -32'sd8, 0, 1, 1, 0, 0, 30'h10, 1, 0, 0));
        vecs.push_back(mk(1, CMP, 30'h10, -32'sd8, 0, 1, 1, 0, 1, 30'h10, 1, 0, 0));
        vecs.push_back(mk(1, CMP, 30'h10, -32'sd8, 0, 1, 1, 0, 1, 30'h10, 1, 0, 0));
        vecs.push_back(mk(1, CMP, 30'h10, -32'sd8, 0, 1, 1, 0, 1, 30'h10, 1, 0, 0));
        vecs.push_back(mk(1, CMP, 30'h10, -32'sd8, 0, 0, 1, 0, 1, 30'h10, 1, 1, 30'h11));
        vecs.push_back(idle(30'h10, 1'b1));
        vecs.push_back(mk(1, CMP, 30'h10, -32'sd8, 0, 0, 1, 0, 0, 30'h10, 1, 0, 0));
        vecs.push_back(idle(30'h10, 1'b0));
        vecs.push_back(mk(1, ALU, 30'h20, 0, 32'h0000_1004, 0, 0, 0, 1, 30'h20, 0, 1, 30'h401));
        vecs.push_back(mk(1, CMP, 30'h20, 32'sd4, 0, 1, 1, 0, 0, 30'h20, 0, 0, 0));
        vecs.push_back(idle(30'h20, 1'b0));
        vecs.push_back(mk(1, JMP, 30'h100, 32'sd16, 0, 0, 0, 0, 0, 30'h100, 0, 1, 30'h104));
        vecs.push_back(idle(30'h100, 1'b0));
        vecs.push_back(mk(1, JMP, 30'h100, 32'sd16, 0, 0, 0, 0, 1, 30'h100, 0, 0, 0));
        vecs.push_back(mk(1, CMP, 30'h3FFF_FFFF, 32'sd64, 0, 1, 0, 0, 1, 30'h3F, 0, 1, 30'h0));
        vecs.push_back(idle(30'h3F, 1'b0));
        vecs.push_back(mk(1, CMP, 30'h30, 32'sd64, 32'h1, 0, 0, 1, 1, 30'h30, 0, 1, 30'h31));
        vecs.push_back(idle(30'h30, 1'b0));
        vecs.push_back(mk(1, DIS, 30'h40, 32'sd64, 0, 1, 1, 0, 1, 30'h40, 0, 0, 0));
        vecs.push_back(mk(1, JMP, 30'h1, -32'sd16, 0, 0, 0, 0, 0, 30'h1, 0, 1, 30'h3FFF_FFFD));
        vecs.push_back(idle(30'h1, 1'b0));
        vecs.push_back(mk(1, CMP, 30'h5, 32'sd8, 32'h1, 0, 0, 0, 1, 30'h5, 0, 0, 0));
        vecs.push_back(idle(30'h5, 1'b1));

        // Reset values.
        #2;
        chk("rst_redirect", PCW'(redirect), '0);
        chk("rst_squash", PCW'(squash), '0);
        chk("rst_redirect_pc", redirect_pc, '0);
        chk("rst_fpred", PCW'(f_pred_taken), '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) step(vecs[i]);

        // Reset asserted while a redirect is on the outputs.
        step(mk(1, JMP, 30'h40, 32'sd4, 0, 0, 0, 0, 0, 30'h5, 1, 1, 30'h41));
        rst_n = 1'b0;
        #1;
        chk("midrst_redirect", PCW'(redirect), '0);
        chk("midrst_squash", PCW'(squash), '0);
        chk("midrst_pc", redirect_pc, '0);
        f_pc = 30'h5;
        #1;
        chk("midrst_bht", PCW'(f_pred_taken), '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(idle(30'h40, 1'b0));

        // Five accepted branches, two mispredicts, one ignored in a redirect cycle.
        step(mk(1, JMP, 30'h50, 32'sd8, 0, 0, 0, 0, 1, 30'h50, 0, 0, 0));
        step(mk(1, JMP, 30'h50, 32'sd8, 0, 0, 0, 0, 0, 30'h50, 0, 1, 30'h52));
        step(mk(1, JMP, 30'h60, 32'sd8, 0, 0, 0, 0, 0, 30'h60, 0, 0, 0));
        step(mk(1, JMP, 30'h60, 32'sd8, 0, 0, 0, 0, 1, 30'h60, 0, 0, 0));
        step(mk(1, CMP, 30'h61, 32'sd8, 0, 1, 1, 0, 1, 30'h61, 0, 0, 0));
        step(mk(1, ALU, 30'h62, 0, 32'h0000_0800, 0, 0, 0, 1, 30'h62, 0, 1, 30'h200));
        step(idle(30'h61, 1'b1));
`ifdef BRANCH_STATS_EN
        chk("stat_branches", PCW'(stat_branches), PCW'(5));
        chk("stat_mispredicts", PCW'(stat_mispredicts), PCW'(2));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
